vector_instr_dispatch: RTL and testbench
========================================

# vector_instr_dispatch

Broadcasts a single upstream 64-bit instruction stream to the per-slice instruction ports of the vector datapath. Slices are selected by a per-instruction mask. Each selected slice may accept in a different cycle. The block holds each instruction until every selected slice has taken it, then retires it. It sits between the instruction sequencer and the `t_instr_<n>_dat` / `instr_<n>_valid` / `instr_<n>_ready` ports of the vector datapath top.

## Interface
Parameters:
- `SLICES`, default 16: number of vector slices; must be at least 1.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `t_instr_dat`, in, 64: instruction word.
- `t_instr_mask`, in, `SLICES`: bit n set means slice n receives the instruction.
- `t_instr_valid`, in, 1: upstream valid.
- `t_instr_ready`, out, 1: upstream ready.
- `i_instr_dat`, out, `SLICES*64`: slice n occupies bits [n*64+63 : n*64]; every slice sees the same held word.
- `i_instr_valid`, out, `SLICES`: per-slice valid.
- `i_instr_ready`, in, `SLICES`: per-slice ready.
- `halt`, in, 1: level input; blocks acceptance of new upstream instructions.
- `idle`, out, 1: no instruction is held.
- `retired_cnt`, out, `CNT_W`: count of fully retired instructions.

## Operation
State:
- `hold_dat` (64 bits): the held instruction word.
- `pending` (`SLICES` bits): selected slices that have not yet accepted.
- `busy` = |`pending`.

Per-cycle logic:
- `fire` = `pending` & `i_instr_ready`.
- `last` = `busy` && ((`pending` & ~`fire`) == 0).
- `i_instr_valid` = `pending`. Every `i_instr_dat` lane = `hold_dat`.
- `t_instr_ready` = !`halt` && (!`busy` || `last`).
- `acc` = `t_instr_valid` && `t_instr_ready`.

Register update:
- When `acc`: `hold_dat` <= `t_instr_dat`; `pending` <= `t_instr_mask`.
- When !`acc`: `pending` <= `pending` & ~`fire`.

Retire counter:
- `retired_cnt` increments by 1 on each cycle where `last` is true.
- It also increments by 1 when `acc` occurs with an all-zero mask. That instruction is consumed with no slice traffic and `busy` stays 0.
- If both events occur in the same cycle, the counter increments by 2.
- The counter wraps modulo 2^`CNT_W`.

Handshake rules:
- Once `i_instr_valid[n]` is asserted, it stays high with `hold_dat` stable until slice n fires.
- `halt` never retracts a pending valid. It only blocks new acceptance, so an in-flight instruction always drains while halted.
- Upstream data and mask are sampled only on `acc`. While `t_instr_ready` is low they are ignored.

`idle` = !`busy`.

Reset (asynchronous, active-high) forces:
- `pending` = 0, so `i_instr_valid` = 0 and `idle` = 1.
- `retired_cnt` = 0.
- `hold_dat` = 0, so `i_instr_dat` = 0.
- `t_instr_ready` = !`halt`.

Reset mid-operation discards the held instruction without retiring it. The counter does not increment.

## Timing
- Latency: an instruction accepted at edge N has its masked `i_instr_valid` bits high from edge N onward, i.e. visible in cycle N+1.
- Throughput: one instruction per cycle when all masked slices are ready. The last slice firing in cycle M lets the next instruction be accepted in the same cycle M, so valids stay continuously high with no bubble.
- `t_instr_ready` has a combinational path from `i_instr_ready` and `halt`. There is no combinational path from `t_instr_valid` to any ready.
- Slices fire independently. A slice that has already fired sees its valid low until the next accept.
- `retired_cnt` and `idle` are registered-state derived and update at the edge after the retiring fire.

## Test plan
- **Single full broadcast.** `SLICES`=16, mask 0xFFFF, dat 0xDEAD_BEEF_0000_0001, all ready high.
  - Required: all 16 valids high for exactly one cycle, every lane = 0xDEAD_BEEF_0000_0001.
  - Required: `retired_cnt` 0→1, `idle` back to 1.
- **Staggered acceptance.** Mask 0x0005. Slice 0 ready at cycle 1, slice 2 ready at cycle 4.
  - Required: `i_instr_valid` = 0x0005, then 0x0004 for cycles 2–4, then 0.
  - Required: `t_instr_ready` low in cycles 1–3 and high in cycle 4. The counter increments once.
- **Back-to-back stream.** 8 instructions with mask 0x00FF, all ready high, `t_instr_valid` continuous.
  - Required: one accept per cycle, valid 0x00FF on 8 consecutive cycles with the lane data matching each instruction in order, final `retired_cnt` = 8.
- **Halt during drain.** Mask 0x0003, slice 1 held not-ready, `halt` asserted the cycle after accept, slice 1 ready 3 cycles later.
  - Required: valid bit 1 stays high and `hold_dat` stays stable until slice 1 fires.
  - Required: `t_instr_ready` stays 0 while `halt` is 1.
  - Required: after `halt` drops, the next instruction is accepted in the same cycle.
- **Empty mask and wrap.** `CNT_W`=4, preload 15 retirements, then send one instruction with mask 0.
  - Required: the instruction is accepted with no `i_instr_valid` activity and `retired_cnt` wraps 15→0.
- **Reset mid-flight.** Mask 0x0010 pending with slice 4 not ready. Assert `reset` asynchronously between edges.
  - Required: `i_instr_valid` = 0, `idle` = 1 and `retired_cnt` = 0 immediately, with no retirement counted.

Source files
------------

// File: rtl/vector_instr_dispatch.sv
// rtl/vector_instr_dispatch.sv - broadcasts one upstream instruction to masked vector slices
module vector_instr_dispatch #(
    parameter int SLICES = 16,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          t_instr_dat,
    input  logic [SLICES-1:0]    t_instr_mask,
    input  logic                 t_instr_valid,
    output logic                 t_instr_ready,
    output logic [SLICES*64-1:0] i_instr_dat,
    output logic [SLICES-1:0]    i_instr_valid,
    input  logic [SLICES-1:0]    i_instr_ready,
    input  logic                 halt,
    output logic                 idle,
    output logic [CNT_W-1:0]     retired_cnt
);

    logic [63:0]       hold_dat;
    logic [SLICES-1:0] pending;
    logic [SLICES-1:0] fire;
    logic              busy;
    logic              last;
    logic              acc;
    logic              empty_acc;

    assign fire      = pending & i_instr_ready;
    assign busy      = |pending;
    assign last      = busy && ((pending & ~fire) == '0);
    // Accepting on the last fire keeps valids continuous with no bubble.
    assign t_instr_ready = !halt && (!busy || last);
    assign acc       = t_instr_valid && t_instr_ready;
    assign empty_acc = acc && (t_instr_mask == '0);

    assign i_instr_valid = pending;
    assign i_instr_dat   = {SLICES{hold_dat}};
    assign idle          = !busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_dat <= '0;
            pending  <= '0;
        end else if (acc) begin
            hold_dat <= t_instr_dat;
            pending  <= t_instr_mask;
        end else begin
            pending  <= pending & ~fire;
        end
    end

    // A held instruction retiring and an empty-mask accept can coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
        end else begin
            retired_cnt <= retired_cnt + CNT_W'(last) + CNT_W'(empty_acc);
        end
    end

endmodule

// File: tb/tb_vector_instr_dispatch.sv
// tb/tb_vector_instr_dispatch.sv - directed self-checking bench for vector_instr_dispatch
module tb_vector_instr_dispatch;

    localparam int SLICES = 16;
    localparam int CNT_W  = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [63:0]          t_instr_dat;
    logic [SLICES-1:0]    t_instr_mask;
    logic                 t_instr_valid;
    logic                 t_instr_ready;
    logic [SLICES*64-1:0] i_instr_dat;
    logic [SLICES-1:0]    i_instr_valid;
    logic [SLICES-1:0]    i_instr_ready;
    logic                 halt;
    logic                 idle;
    logic [CNT_W-1:0]     retired_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt;

    vector_instr_dispatch #(.SLICES(SLICES), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .t_instr_dat   (t_instr_dat),
        .t_instr_mask  (t_instr_mask),
        .t_instr_valid (t_instr_valid),
        .t_instr_ready (t_instr_ready),
        .i_instr_dat   (i_instr_dat),
        .i_instr_valid (i_instr_valid),
        .i_instr_ready (i_instr_ready),
        .halt          (halt),
        .idle          (idle),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; halt = 1'b0; t_instr_valid = 1'b0;
        t_instr_dat = '0; t_instr_mask = '0; i_instr_ready = '0;
        #1;
        n_checks++; if (i_instr_valid !== 16'h0) begin n_fail++; $display("FAIL reset_valid got=%h exp=0", i_instr_valid); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got=%b exp=1", idle); end
        n_checks++; if (retired_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", retired_cnt); end
        n_checks++; if (i_instr_dat !== '0) begin n_fail++; $display("FAIL reset_dat got=%h exp=0", i_instr_dat[63:0]); end
        n_checks++; if (t_instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tready got=%b exp=1", t_instr_ready); end
        halt = 1'b1; #1;
        n_checks++; if (t_instr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tready_halt got=%b exp=0", t_instr_ready); end
        halt = 1'b0;
        @(negedge clk); reset = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_full_broadcast();
        @(negedge clk);
        i_instr_ready = 16'hFFFF;
        t_instr_valid = 1'b1; t_instr_mask = 16'hFFFF; t_instr_dat = 64'hDEAD_BEEF_0000_0001;
        #1;
        n_checks++; if (t_instr_ready !== 1'b1) begin n_fail++; $display("FAIL bc_tready got=%b exp=1", t_instr_ready); end
        @(negedge clk); t_instr_valid = 1'b0; #1;
        n_checks++; if (i_instr_valid !== 16'hFFFF) begin n_fail++; $display("FAIL bc_valid got=%h exp=ffff", i_instr_valid); end
        for (int n = 0; n < SLICES; n++) begin
            n_checks++;
            if (i_instr_dat[n*64 +: 64] !== 64'hDEAD_BEEF_0000_0001) begin
                n_fail++; $display("FAIL bc_lane%0d got=%h exp=deadbeef00000001", n, i_instr_dat[n*64 +: 64]);
            end
        end
        @(negedge clk); #1;
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (i_instr_valid !== 16'h0) begin n_fail++; $display("FAIL bc_valid_after got=%h exp=0", i_instr_valid); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL bc_idle got=%b exp=1", idle); end
        n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL bc_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
    endtask

    task automatic test_staggered();
        logic [15:0] exp_v [1:4];
        logic [15:0] rdy   [1:4];
        logic        exp_r [1:4];
        exp_v = '{16'h0005, 16'h0004, 16'h0004, 16'h0004};
        rdy   = '{16'h0001, 16'h0000, 16'h0000, 16'h0004};
        exp_r = '{1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        i_instr_ready = '0;
        t_instr_valid = 1'b1; t_instr_mask = 16'h0005; t_instr_dat = 64'h1111_2222_3333_4444;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            t_instr_valid = 1'b0; i_instr_ready = rdy[c]; #1;
            n_checks++; if (i_instr_valid !== exp_v[c]) begin n_fail++; $display("FAIL stg_valid_c%0d got=%h exp=%h", c, i_instr_valid, exp_v[c]); end
            n_checks++; if (t_instr_ready !== exp_r[c]) begin n_fail++; $display("FAIL stg_tready_c%0d got=%b exp=%b", c, t_instr_ready, exp_r[c]); end
        end
        @(negedge clk); i_instr_ready = '0; #1;
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (i_instr_valid !== 16'h0) begin n_fail++; $display("FAIL stg_valid_end got=%h exp=0", i_instr_valid); end
        n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL stg_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] dats [8];
        for (int k = 0; k < 8; k++) dats[k] = 64'hA5A5_0000_0000_0000 | 64'(k * 17 + 3);
        @(negedge clk);
        i_instr_ready = 16'hFFFF;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            t_instr_valid = (k < 8); t_instr_mask = 16'h00FF;
            t_instr_dat = (k < 8) ? dats[k] : 64'h0;
            #1;
            if (k < 8) begin
                n_checks++; if (t_instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_tready_k%0d got=%b exp=1", k, t_instr_ready); end
            end
            if (k > 0) begin
                n_checks++; if (i_instr_valid !== 16'h00FF) begin n_fail++; $display("FAIL b2b_valid_k%0d got=%h exp=00ff", k, i_instr_valid); end
                n_checks++; if (i_instr_dat[7*64 +: 64] !== dats[k-1]) begin n_fail++; $display("FAIL b2b_dat_k%0d got=%h exp=%h", k, i_instr_dat[7*64 +: 64], dats[k-1]); end
            end
        end
        @(negedge clk); #1;
        exp_cnt = exp_cnt + 4'd8;
        n_checks++; if (i_instr_valid !== 16'h0) begin n_fail++; $display("FAIL b2b_valid_end got=%h exp=0", i_instr_valid); end
        n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
    endtask

    task automatic test_halt_drain();
        @(negedge clk);
        i_instr_ready = 16'h0001;
        t_instr_valid = 1'b1; t_instr_mask = 16'h0003; t_instr_dat = 64'hAAAA_0000_0000_000A;
        @(negedge clk);
        t_instr_valid = 1'b1; t_instr_dat = 64'hBBBB_0000_0000_000B; halt = 1'b1; #1;
        n_checks++; if (i_instr_valid !== 16'h0003) begin n_fail++; $display("FAIL hlt_valid_c1 got=%h exp=0003", i_instr_valid); end
        n_checks++; if (t_instr_ready !== 1'b0) begin n_fail++; $display("FAIL hlt_tready_c1 got=%b exp=0", t_instr_ready); end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk); #1;
            n_checks++; if (i_instr_valid !== 16'h0002) begin n_fail++; $display("FAIL hlt_valid_c%0d got=%h exp=0002", c, i_instr_valid); end
            n_checks++; if (i_instr_dat[63:0] !== 64'hAAAA_0000_0000_000A) begin n_fail++; $display("FAIL hlt_dat_c%0d got=%h exp=aaaa00000000000a", c, i_instr_dat[63:0]); end
            n_checks++; if (t_instr_ready !== 1'b0) begin n_fail++; $display("FAIL hlt_tready_c%0d got=%b exp=0", c, t_instr_ready); end
        end
        @(negedge clk);
        i_instr_ready = 16'h0003; #1;
        n_checks++; if (t_instr_ready !== 1'b0) begin n_fail++; $display("FAIL hlt_tready_halted got=%b exp=0", t_instr_ready); end
        halt = 1'b0; #1;
        n_checks++; if (t_instr_ready !== 1'b1) begin n_fail++; $display("FAIL hlt_tready_release got=%b exp=1", t_instr_ready); end
        @(negedge clk);
        t_instr_valid = 1'b0; i_instr_ready = 16'hFFFF; #1;
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (i_instr_valid !== 16'h0003) begin n_fail++; $display("FAIL hlt_valid_next got=%h exp=0003", i_instr_valid); end
        n_checks++; if (i_instr_dat[64 +: 64] !== 64'hBBBB_0000_0000_000B) begin n_fail++; $display("FAIL hlt_dat_next got=%h exp=bbbb00000000000b", i_instr_dat[64 +: 64]); end
        n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL hlt_cnt_a got=%0d exp=%0d", retired_cnt, exp_cnt); end
        @(negedge clk); #1;
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL hlt_idle got=%b exp=1", idle); end
        n_checks++; if (retired_cnt !== exp_cnt) begin n_fail++; $display("FAIL hlt_cnt_b got=%0d exp=%0d", retired_cnt, exp_cnt); end
    endtask

    task automatic test_empty_mask_wrap();
        int n_pre;
        n_pre = 15 - int'(exp_cnt);
        i_instr_ready = 16'hFFFF;
        for (int i = 0; i < n_pre; i++) begin
            @(negedge clk);
            t_instr_valid = 1'b1; t_instr_mask = 16'h0001; t_instr_dat = 64'(i);
            @(negedge clk);
            t_instr_valid = 1'b0;
            exp_cnt = exp_cnt + 4'd1;
        end
        @(negedge clk); #1;
        n_checks++; if (retired_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_preload got=%0d exp=15", retired_cnt); end
        t_instr_valid = 1'b1; t_instr_mask = 16'h0000; t_instr_dat = 64'h0E0E; #1;
        n_checks++; if (t_instr_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_tready got=%b exp=1", t_instr_ready); end
        @(negedge clk);
        t_instr_valid = 1'b0; #1;
        n_checks++; if (i_instr_valid !== 16'h0) begin n_fail++; $display("FAIL wrap_valid got=%h exp=0", i_instr_valid); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL wrap_idle got=%b exp=1", idle); end
        n_checks++; if (retired_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt got=%0d exp=0", retired_cnt); end
        // retirement and empty-mask accept in the same cycle
        t_instr_valid = 1'b1; t_instr_mask = 16'h0001; t_instr_dat = 64'h1234;
        @(negedge clk);
        t_instr_mask = 16'h0000; #1;
        n_checks++; if (t_instr_ready !== 1'b1) begin n_fail++; $display("FAIL dbl_tready got=%b exp=1", t_instr_ready); end
        @(negedge clk);
        t_instr_valid = 1'b0; #1;
        n_checks++; if (retired_cnt !== 4'd2) begin n_fail++; $display("FAIL dbl_cnt got=%0d exp=2", retired_cnt); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL dbl_idle got=%b exp=1", idle); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        i_instr_ready = '0;
        t_instr_valid = 1'b1; t_instr_mask = 16'h0010; t_instr_dat = 64'h4444;
        @(negedge clk);
        t_instr_valid = 1'b0; #1;
        n_checks++; if (i_instr_valid !== 16'h0010) begin n_fail++; $display("FAIL rst_pending got=%h exp=0010", i_instr_valid); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (i_instr_valid !== 16'h0) begin n_fail++; $display("FAIL rst_valid got=%h exp=0", i_instr_valid); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got=%b exp=1", idle); end
        n_checks++; if (retired_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", retired_cnt); end
        n_checks++; if (i_instr_dat !== '0) begin n_fail++; $display("FAIL rst_dat got=%h exp=0", i_instr_dat[4*64 +: 64]); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (retired_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_cnt_after got=%0d exp=0", retired_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_broadcast();
        test_staggered();
        test_back_to_back();
        test_halt_drain();
        test_empty_mask_wrap();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
